// File: rtl/nibble_add_sequencer.sv
// Drives an external 4-bit combinational adder one nibble per cycle to form a 4*WORDS-bit sum.
// Optional saturation on final carry-out is enabled by defining NIBBLE_ADD_SAT_EN.
module nibble_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*WORDS-1:0] a,
    input  logic [4*WORDS-1:0] b,
    input  logic               cin,
    output logic [3:0]         add_in1,
    output logic [3:0]         add_in2,
    output logic               add_ic,
    input  logic [3:0]         add_out,
    input  logic [3:0]         add_oc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*WORDS-1:0] sum,
    output logic               cout
);

    localparam int W  = 4 * WORDS;
    localparam int KW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    sum_r;
    logic            carry_r;
    logic            cout_r;
    logic [KW-1:0]   k_r;
    logic            last_s;
    logic [KW+1:0]   base_s;

    assign last_s    = (k_r == KW'(WORDS - 1));
    assign base_s    = {k_r, 2'b00};
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE: begin
                if (out_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Present the current nibble pair and chained carry to the adder; quiet otherwise
    always_comb begin
        add_in1 = 4'd0;
        add_in2 = 4'd0;
        add_ic  = 1'b0;
        if (state_r == RUN) begin
            add_in1 = a_r[base_s +: 4];
            add_in2 = b_r[base_s +: 4];
            add_ic  = carry_r;
        end else begin
            add_in1 = 4'd0;
            add_in2 = 4'd0;
            add_ic  = 1'b0;
        end
    end

    // State, operand capture, nibble index, carry chain and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            k_r     <= {KW{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        k_r     <= {KW{1'b0}};
                    end
                end
                RUN: begin
                    carry_r <= add_oc[3];
                    if (last_s) begin
                        cout_r <= add_oc[3];
`ifdef NIBBLE_ADD_SAT_EN
                        // Overflow clamps the whole word rather than wrapping
                        if (add_oc[3]) sum_r <= {W{1'b1}};
                        else           sum_r[base_s +: 4] <= add_out;
`else
                        sum_r[base_s +: 4] <= add_out;
`endif
                    end else begin
                        sum_r[base_s +: 4] <= add_out;
                        k_r                <= k_r + KW'(1);
                    end
                end
                DONE: begin
                    carry_r <= carry_r;
                end
                default: begin
                    carry_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Self-checking bench: behavioural 4-bit adder plus whole-word arithmetic reference.
module tb_nibble_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [3:0]   add_in1;
    logic [3:0]   add_in2;
    logic         add_ic;
    logic [3:0]   add_out;
    logic [3:0]   add_oc;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    nibble_add_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .add_in1(add_in1), .add_in2(add_in2), .add_ic(add_ic),
        .add_out(add_out), .add_oc(add_oc),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ripple-carry model of the external 4-bit adder
    always_comb begin
        logic c;
        c = add_ic;
        add_out = 4'd0;
        add_oc  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            add_out[i] = add_in1[i] ^ add_in2[i] ^ c;
            c          = (add_in1[i] & add_in2[i]) | (c & (add_in1[i] ^ add_in2[i]));
            add_oc[i]  = c;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts in IDLE at a negedge; ends at a negedge back in IDLE
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input int hold, input bit keep_valid);
        logic [W:0]   full;
        logic [W:0]   part;
        logic [W:0]   mk;
        logic [W-1:0] exp_sum;
        logic         exp_c;
        full    = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc);
        exp_c   = full[W];
        exp_sum = full[W-1:0];
`ifdef NIBBLE_ADD_SAT_EN
        if (exp_c) exp_sum = {W{1'b1}};
`endif
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        acc_cyc = cyc;
        for (int k = 0; k < WORDS; k++) begin
            @(negedge clk);
            mk   = ((W+1)'(1) << (4*k)) - (W+1)'(1);
            part = ({1'b0, ta} & mk) + ({1'b0, tb_} & mk) + (W+1)'(tc);
            chk("run_in1", add_in1, (ta >> (4*k)) & 4'hF);
            chk("run_in2", add_in2, (tb_ >> (4*k)) & 4'hF);
            chk("run_ic", add_ic, (part >> (4*k)) & 1);
            chk("run_out_valid", out_valid, 0);
            chk("run_in_ready", in_ready, 0);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            in_valid  = keep_valid ? 1'b1 : 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        chk("done_valid", out_valid, 1);
        chk("done_sum", sum, exp_sum);
        chk("done_cout", cout, exp_c);
        chk("done_in_ready", in_ready, 0);
        chk("done_in1_zero", add_in1, 0);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, exp_sum);
            chk("hold_cout", cout, exp_c);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
        out_ready = 1'b0;
        in_valid  = keep_valid ? 1'b1 : 1'b0;
    endtask

    initial begin
        int t1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_add", {add_in1, add_in2, add_ic}, 0);

        run_op(16'h0002, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b0, 3, 1'b0);

        // Abort mid-operation with reset at nibble 2
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_k2_in1", add_in1, 4'hA);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sum", sum, 0);
        chk("abort_add_in1", add_in1, 0);
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

        // Back-to-back with in_valid held high throughout
        run_op(16'h0F0F, 16'h0101, 1'b1, 0, 1'b1);
        t1 = acc_cyc;
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b1);
        chk("b2b_gap", 64'(acc_cyc - t1), 64'(WORDS + 2));
        in_valid = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
